// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the BCD run-control blocks: state encoding, digit range
// and the terminal-value validity check.
package bcd_count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // A limit is usable only if every digit is decimal and it is not all-zero;
  // anything else means free-run.
  function automatic logic bcd_limit_valid(input logic [11:0] lim);
    return (lim[11:8] <= BCD_DIGIT_MAX) &&
           (lim[7:4]  <= BCD_DIGIT_MAX) &&
           (lim[3:0]  <= BCD_DIGIT_MAX) &&
           (lim != 12'h000);
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_prescaler.sv
// Divide-by-DIV step prescaler: counts while run is high, holds otherwise,
// and asserts tick on its last phase.
module bcd_prescaler #(
  parameter int DIV   = 4,
  parameter int PRE_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  always_comb begin
    // NOTE: default assignment first, so every path assigns pre_d and no latch is inferred.
    pre_d = pre_q;
    if (sync_clr) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = (pre_q == PRE_MAX);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a 3-digit BCD counter: start/stop/clear commands,
// prescaled enable strobes, programmable BCD stop value and sticky overflow.
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int PRE_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [11:0] limit,
  input  logic [11:0] cnt_q,
  input  logic        cnt_carry,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  state_e state_q, state_d;
  logic   cnt_clr_q, cnt_clr_d;
  logic   overflow_q, overflow_d;
  logic   limit_valid, at_limit, pre_run, tick;

  assign limit_valid = bcd_limit_valid(limit);
  // During the cnt_clr cycle the counter still shows its pre-clear value, so a
  // match there is stale (e.g. restart from DONE) and must not count.
  assign at_limit = limit_valid && (cnt_q == limit) && !cnt_clr_q;
  assign pre_run  = (state_q == ST_RUN) && !at_limit;

  // Every cnt_clr-producing transition also re-phases the prescaler.
  bcd_prescaler #(
    .DIV  (DIV),
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .run     (pre_run),
    .sync_clr(cnt_clr_d),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_clr_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_clr_q  <= cnt_clr_d;
      overflow_q <= overflow_d;
    end
  end

  // Command priority is clear > stop > start.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (at_limit) begin
          state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (clear || start) begin
          state_d   = clear ? ST_IDLE : ST_RUN;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (cnt_clr_q) begin
      overflow_d = 1'b0;
    end else if (cnt_en && cnt_carry) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    cnt_en   = busy && tick && !at_limit;
    cnt_clr  = cnt_clr_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (DIV=4 and DIV=1) each drive a
// behavioural BCD counter; outputs are checked every cycle against a reference model.
module tb_bcd_count_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, stop, clear;
  logic [11:0]       limit;
  logic [1:0][11:0]  cnt_q;
  logic [1:0]        cnt_carry;
  logic [1:0]        cnt_en, cnt_clr, busy, done, overflow;

  bcd_count_ctrl #(.DIV(4), .PRE_W(2)) u_dut_div4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .limit(limit), .cnt_q(cnt_q[0]), .cnt_carry(cnt_carry[0]),
    .cnt_en(cnt_en[0]), .cnt_clr(cnt_clr[0]), .busy(busy[0]),
    .done(done[0]), .overflow(overflow[0])
  );

  bcd_count_ctrl #(.DIV(1), .PRE_W(1)) u_dut_div1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .limit(limit), .cnt_q(cnt_q[1]), .cnt_carry(cnt_carry[1]),
    .cnt_en(cnt_en[1]), .cnt_clr(cnt_clr[1]), .busy(busy[1]),
    .done(done[1]), .overflow(overflow[1])
  );

  always #5 clk = ~clk;

  // Reference model: run mode, count of counting RUN cycles since the last
  // (re)start, pending clear pulse, sticky overflow, and the counter value.
  int         mode    [2];
  int         rc      [2];
  bit         clr_p   [2];
  bit         ovf_m   [2];
  int         cnt_val [2];
  logic [4:0] last_obs[2];
  int         n_checks, n_errors, cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Decimal value of a limit, or -1 when it selects free-run.
  function automatic int lim_val(input logic [11:0] l);
    int h, t, o;
    h = int'(l[11:8]);
    t = int'(l[7:4]);
    o = int'(l[3:0]);
    if (h > 9 || t > 9 || o > 9 || l == 12'h000) return -1;
    return h * 100 + t * 10 + o;
  endfunction

  function automatic logic [4:0] obs(input int i);
    return {cnt_en[i], cnt_clr[i], busy[i], done[i], overflow[i]};
  endfunction

  function automatic bit model_at(input int i);
    int lv;
    lv = lim_val(limit);
    return (lv >= 0) && (lv == cnt_val[i]) && !clr_p[i];
  endfunction

  function automatic logic [4:0] exp_vec(input int i, input bit at);
    logic e_en;
    e_en = (mode[i] == M_RUN) && ((rc[i] % div_of(i)) == div_of(i) - 1) && !at;
    return {e_en, clr_p[i], mode[i] == M_RUN, mode[i] == M_DONE, ovf_m[i]};
  endfunction

  task automatic sync_env(input int i);
    cnt_q[i]     = to_bcd(cnt_val[i]);
    cnt_carry[i] = (cnt_val[i] == 999);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i]  = M_IDLE;
      rc[i]    = 0;
      clr_p[i] = 1'b0;
      ovf_m[i] = 1'b0;
    end
  endtask

  // One clock cycle: drive commands, compare outputs mid-cycle, then advance
  // the counter (from DUT outputs) and the model (from the rules) after the edge.
  task automatic cycle(input bit s, input bit p, input bit c);
    logic [4:0] o[2];
    logic [4:0] e[2];
    bit         at[2];
    bit         nclr;
    @(negedge clk);
    start = s; stop = p; clear = c;
    #1;
    for (int i = 0; i < 2; i++) begin
      at[i]       = model_at(i);
      e[i]        = exp_vec(i, at[i]);
      o[i]        = obs(i);
      last_obs[i] = o[i];
      check($sformatf("cyc%0d_div%0d", cyc, div_of(i)), 32'(o[i]), 32'(e[i]));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (e[i][3]) ovf_m[i] = 1'b0;
      else if (e[i][4] && cnt_val[i] == 999) ovf_m[i] = 1'b1;
      if (o[i][3]) cnt_val[i] = 0;
      else if (o[i][4]) cnt_val[i] = (cnt_val[i] + 1) % 1000;
      if (mode[i] == M_RUN && !at[i]) rc[i]++;
      nclr = 1'b0;
      case (mode[i])
        M_IDLE:  if (s) begin mode[i] = M_RUN; nclr = 1'b1; rc[i] = 0; end
        M_RUN:   if (c) begin mode[i] = M_IDLE; nclr = 1'b1; rc[i] = 0; end
                 else if (p) mode[i] = M_PAUSE;
                 else if (at[i]) mode[i] = M_DONE;
        M_PAUSE: if (c) begin mode[i] = M_IDLE; nclr = 1'b1; rc[i] = 0; end
                 else if (s) mode[i] = M_RUN;
        default: if (c) begin mode[i] = M_IDLE; nclr = 1'b1; rc[i] = 0; end
                 else if (s) begin mode[i] = M_RUN; nclr = 1'b1; rc[i] = 0; end
      endcase
      clr_p[i] = nclr;
      sync_env(i);
    end
  endtask

  task automatic mid_reset();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("rst_async_div%0d", div_of(i)), 32'(obs(i)), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int seen_done;
    n_checks = 0; n_errors = 0; cyc = 0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; limit = 12'h000;
    for (int i = 0; i < 2; i++) begin
      cnt_val[i] = 0;
      sync_env(i);
    end
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_outputs_div%0d", div_of(i)), 32'(obs(i)), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cycle(0, 0, 0);

    // Count to 005 with DIV=4: clr in cycle 1, strobes in 4,8,..,20, done from 22.
    limit = 12'h005;
    cycle(1, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      cycle(0, 0, 0);
      check($sformatf("t2_k%0d", k), 32'(last_obs[0][4:1]),
            32'({(k % 4 == 0) && (k <= 20), k == 1, k < 22, k >= 22}));
    end
    repeat (50) cycle(0, 0, 0);
    check("t2_hold_q", 32'(cnt_q[0]), 32'h005);
    check("t2_hold_done", 32'(last_obs[0][2:1]), 32'b01);

    // Restart from DONE, pause at 002 after one prescaler phase, then resume.
    limit = 12'h050;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("t6_restart_clr", 32'(last_obs[0][3]), 32'd1);
    check("t6_restart_zero", 32'(cnt_q[0]), 32'h000);
    repeat (7) cycle(0, 0, 0);
    check("t3_q_at_stop", 32'(cnt_q[0]), 32'h002);
    cycle(0, 1, 0);
    for (int k = 0; k < 30; k++) begin
      cycle(0, 0, 0);
      check($sformatf("t3_paused_k%0d", k), 32'({last_obs[0][4], last_obs[0][2]}), 32'd0);
    end
    check("t3_q_paused", 32'(cnt_q[0]), 32'h002);
    cycle(1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 0, 0);
      check($sformatf("t3_resume_k%0d", k), 32'(last_obs[0][4]), 32'(k == 3));
    end

    // Simultaneous clear+stop+start in RUN: clear wins, one clr pulse.
    cycle(1, 1, 1);
    cycle(0, 0, 0);
    check("t5_clr_pulse", 32'(last_obs[0][3:1]), 32'b100);
    cycle(0, 0, 0);
    check("t5_single_pulse", 32'(last_obs[0][3:1]), 32'b000);

    // Free-run through 999 -> 000 with DIV=1.
    limit = 12'h000;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cnt_val[1] = 998;
    sync_env(1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("t4_wrap_q", 32'(cnt_q[1]), 32'h000);
    cycle(0, 0, 0);
    check("t4_ovf_busy", 32'({last_obs[1][2], last_obs[1][0]}), 32'b11);
    repeat (20) cycle(0, 0, 0);
    check("t4_ovf_sticky", 32'({last_obs[1][2], last_obs[1][0]}), 32'b11);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    check("t4_clear_clr", 32'(last_obs[1][3]), 32'd1);
    cycle(0, 0, 0);
    check("t4_clear_ovf", 32'(last_obs[1][0]), 32'd0);

    // Invalid digit in limit: free-run, never DONE.
    limit = 12'h0A3;
    cycle(1, 0, 0);
    seen_done = 0;
    for (int k = 0; k < 1100; k++) begin
      cycle(0, 0, 0);
      if (last_obs[0][1] || last_obs[1][1]) seen_done++;
    end
    check("t6_never_done", 32'(seen_done), 32'd0);
    check("t6_wrapped", 32'(last_obs[1][0]), 32'd1);

    // Asynchronous reset while running.
    mid_reset();
    cycle(0, 0, 0);
    check("t1_idle_after", 32'({last_obs[0][2:1], last_obs[1][2:1]}), 32'd0);

    // Randomised commands and limits.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        case ($urandom_range(0, 3))
          0:       limit = 12'h000;
          1:       limit = 12'($urandom);
          2:       limit = to_bcd(int'($urandom_range(0, 40)));
          default: limit = to_bcd((cnt_val[0] + int'($urandom_range(1, 20))) % 1000);
        endcase
      end
      if (n % 997 == 500) mid_reset();
      cycle($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
